// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - shared state encodings, output table and timing helpers for the panel power sequencer
package dsi_pkg;

  typedef enum logic [3:0] {
    S_OFF,
    S_VDD,
    S_AVDD,
    S_RST_REL,
    S_ON,
    S_DSI_OFF,
    S_PD_RST,
    S_PD_AVDD,
    S_FAULT
  } seq_state_t;

  typedef struct packed {
    logic vdd;
    logic avdd;
    logic prst_n;
    logic dsi;
    logic ready;
  } seq_out_t;

  localparam seq_out_t OUT_OFF     = 5'b00000;
  localparam seq_out_t OUT_VDD     = 5'b10000;
  localparam seq_out_t OUT_AVDD    = 5'b11000;
  localparam seq_out_t OUT_RST_REL = 5'b11100;
  localparam seq_out_t OUT_ON      = 5'b11111;

  // A timed state ends on the cycle the counter reaches this limit; 0 and 1 both mean one cycle.
  function automatic logic [23:0] wait_limit(input logic [23:0] t);
    return (t == 24'd0) ? 24'd0 : t - 24'd1;
  endfunction

  function automatic seq_out_t state_outputs(input seq_state_t s);
    case (s)
      S_VDD:     return OUT_VDD;
      S_AVDD:    return OUT_AVDD;
      S_RST_REL: return OUT_RST_REL;
      S_ON:      return OUT_ON;
      S_DSI_OFF: return OUT_RST_REL;
      S_PD_RST:  return OUT_AVDD;
      S_PD_AVDD: return OUT_VDD;
      default:   return OUT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seq_timer.sv
// rtl/seq_timer.sv - clearable saturating up-counter used to time sequencer states
module seq_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != {WIDTH{1'b1}}) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/panel_power_sequencer.sv
// rtl/panel_power_sequencer.sv - DSI panel supply/reset/enable power-up and power-down sequencer
module panel_power_sequencer
  import dsi_pkg::*;
#(
  parameter logic [23:0] T_VDD     = 24'd50000,
  parameter logic [23:0] T_AVDD    = 24'd50000,
  parameter logic [23:0] T_INIT    = 24'd600000,
  parameter logic [23:0] T_DSI_OFF = 24'd10000,
  parameter logic [23:0] T_PD      = 24'd10000,
  parameter logic [23:0] T_PG_TO   = 24'd1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pwr_good,
  output logic vdd_en,
  output logic avdd_en,
  output logic panel_rst_n,
  output logic dsi_en,
  output logic ready,
  output logic fault
);

  localparam logic [23:0] LIM_VDD  = wait_limit(T_VDD);
  localparam logic [23:0] LIM_AVDD = wait_limit(T_AVDD);
  localparam logic [23:0] LIM_INIT = wait_limit(T_INIT);
  localparam logic [23:0] LIM_DSI  = wait_limit(T_DSI_OFF);
  localparam logic [23:0] LIM_PD   = wait_limit(T_PD);
  localparam logic [23:0] LIM_PGTO = wait_limit(T_PG_TO);

  seq_state_t  state;
  seq_state_t  state_next;
  seq_out_t    outs_q;
  logic [23:0] count;

  seq_timer #(.WIDTH(24)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_next != state),
    .count (count)
  );

  // A dropped en request during power-up aborts straight into power-down, ahead of timeouts.
  always_comb begin
    state_next = state;
    case (state)
      S_OFF:     if (en) state_next = S_VDD;
      S_VDD: begin
        if (!en)                   state_next = S_PD_RST;
        else if (count == LIM_VDD) state_next = S_AVDD;
      end
      S_AVDD: begin
        if (!en)                                   state_next = S_PD_RST;
        else if (!pwr_good && count == LIM_PGTO)   state_next = S_FAULT;
        else if (pwr_good && count >= LIM_AVDD)    state_next = S_RST_REL;
      end
      S_RST_REL: begin
        if (!en)                    state_next = S_PD_RST;
        else if (count == LIM_INIT) state_next = S_ON;
      end
      S_ON: begin
        if (!pwr_good) state_next = S_PD_RST;
        else if (!en)  state_next = S_DSI_OFF;
      end
      S_DSI_OFF: if (count == LIM_DSI) state_next = S_PD_RST;
      S_PD_RST:  if (count == LIM_PD)  state_next = S_PD_AVDD;
      S_PD_AVDD: if (count == LIM_PD)  state_next = S_OFF;
      S_FAULT:   if (!en)              state_next = S_OFF;
      default:                         state_next = S_OFF;
    endcase
  end

  // Outputs are registered from the next-state decode so they switch with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_OFF;
      outs_q <= OUT_OFF;
      fault  <= 1'b0;
    end else begin
      state  <= state_next;
      outs_q <= state_outputs(state_next);
      if (state_next == S_FAULT) begin
        fault <= 1'b1;
      end else if (state_next == S_OFF) begin
        fault <= 1'b0;
      end
    end
  end

  assign vdd_en      = outs_q.vdd;
  assign avdd_en     = outs_q.avdd;
  assign panel_rst_n = outs_q.prst_n;
  assign dsi_en      = outs_q.dsi;
  assign ready       = outs_q.ready;

endmodule

// File: tb/tb_panel_power_sequencer.sv
// tb/tb_panel_power_sequencer.sv - randomized scoreboard bench for the panel power sequencer
module tb_panel_power_sequencer;

  localparam int TV = 4, TA = 4, TI = 8, TD = 2, TP = 3, TG = 16;
  localparam int P_OFF = 0, P_VDD = 1, P_AVDD = 2, P_RST = 3, P_ON = 4,
                 P_DSIOFF = 5, P_PDRST = 6, P_PDAVDD = 7, P_FAULT = 8;

  logic clk = 1'b0;
  logic rst_n, en, pwr_good;
  logic vdd_en, avdd_en, panel_rst_n, dsi_en, ready, fault;

  always #5 clk = ~clk;

  panel_power_sequencer #(
    .T_VDD(24'd4), .T_AVDD(24'd4), .T_INIT(24'd8),
    .T_DSI_OFF(24'd2), .T_PD(24'd3), .T_PG_TO(24'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pwr_good(pwr_good),
    .vdd_en(vdd_en), .avdd_en(avdd_en), .panel_rst_n(panel_rst_n),
    .dsi_en(dsi_en), .ready(ready), .fault(fault)
  );

  logic [5:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ph = P_OFF;
  int el = 0;

  function automatic int dur(int x);
    return (x <= 1) ? 1 : x;
  endfunction

  // Expected {vdd, avdd, panel_rst_n, dsi, ready, fault} while in each phase.
  function automatic logic [5:0] levels(int p);
    case (p)
      P_VDD:    return 6'b100000;
      P_AVDD:   return 6'b110000;
      P_RST:    return 6'b111000;
      P_ON:     return 6'b111110;
      P_DSIOFF: return 6'b111000;
      P_PDRST:  return 6'b110000;
      P_PDAVDD: return 6'b100000;
      P_FAULT:  return 6'b000001;
      default:  return 6'b000000;
    endcase
  endfunction

  // el counts cycles already spent in the phase; a phase of length d ends when el+1 reaches d.
  task automatic model_step(input bit r, input bit e, input bit g);
    int nx;
    bit up_done;
    nx = ph;
    if (!r) begin
      ph = P_OFF;
      el = 0;
      return;
    end
    case (ph)
      P_OFF:    nx = e ? P_VDD : P_OFF;
      P_VDD:    nx = !e ? P_PDRST : (el + 1 >= dur(TV) ? P_AVDD : P_VDD);
      P_AVDD: begin
        if (!e)                           nx = P_PDRST;
        else if (!g && el + 1 == dur(TG)) nx = P_FAULT;
        else if (g && el + 1 >= dur(TA))  nx = P_RST;
      end
      P_RST:    nx = !e ? P_PDRST : (el + 1 >= dur(TI) ? P_ON : P_RST);
      P_ON:     nx = !g ? P_PDRST : (!e ? P_DSIOFF : P_ON);
      P_DSIOFF: nx = (el + 1 >= dur(TD)) ? P_PDRST : P_DSIOFF;
      P_PDRST:  nx = (el + 1 >= dur(TP)) ? P_PDAVDD : P_PDRST;
      P_PDAVDD: nx = (el + 1 >= dur(TP)) ? P_OFF : P_PDAVDD;
      P_FAULT:  nx = e ? P_FAULT : P_OFF;
      default:  nx = P_OFF;
    endcase
    up_done = (nx == ph);
    el = up_done ? el + 1 : 0;
    ph = nx;
  endtask

  task automatic cycle(input bit r, input bit e, input bit g);
    rst_n = r;
    en = e;
    pwr_good = g;
    @(posedge clk);
    model_step(r, e, g);
    exp_q.push_back(levels(ph));
    #1;
  endtask

  task automatic hold(input int n, input bit r, input bit e, input bit g);
    for (int i = 0; i < n; i++) cycle(r, e, g);
  endtask

  initial begin : monitor
    logic [5:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {vdd_en, avdd_en, panel_rst_n, dsi_en, ready, fault};
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL outputs cycle %0d: got vdd/avdd/prst/dsi/rdy/flt=%b expected %b", cyc, act_v, exp_v);
        end
      end
    end
  end

  initial begin : stimulus
    bit seg_en, seg_pg;
    int seg_len;
    rst_n = 1'b0;
    en = 1'b0;
    pwr_good = 1'b0;
    hold(3, 0, 1, 1);
    hold(25, 1, 1, 1);
    hold(12, 1, 0, 1);
    hold(30, 1, 1, 0);
    hold(3, 1, 0, 0);
    hold(11, 1, 1, 1);
    hold(1, 1, 0, 1);
    hold(4, 1, 1, 1);
    hold(10, 1, 0, 1);
    hold(25, 1, 1, 1);
    hold(1, 0, 1, 1);
    hold(25, 1, 1, 1);
    hold(1, 1, 1, 0);
    hold(12, 1, 1, 1);
    hold(12, 1, 0, 1);
    for (int s = 0; s < 200; s++) begin
      seg_len = $urandom_range(1, 40);
      seg_en = ($urandom_range(0, 99) < 70);
      seg_pg = ($urandom_range(0, 99) < 80);
      for (int i = 0; i < seg_len; i++) begin
        cycle($urandom_range(0, 99) >= 2, seg_en,
              ($urandom_range(0, 99) < 5) ? !seg_pg : seg_pg);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
